// File: rtl/ram_stream_writer_pkg.sv
// Shared types and default widths for the stream-to-RAM writer and its address generators.
package ram_stream_writer_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FLUSH,
        ST_VERIFY,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ram_stream_writer_wrap_addr_gen.sv
// Address generator: base plus a running offset, wrapping modulo 2^ADDR_W.
module wrap_addr_gen
    import ram_stream_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] off_q, off_d;

    always_comb begin
        off_d = off_q;
        if (clr) begin
            off_d = '0;
        end else if (step) begin
            off_d = off_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    // Natural truncation of the sum gives the DEPTH-1 -> 0 wrap.
    assign addr = base + off_q;

endmodule

// File: rtl/ram_stream_writer.sv
// Streams len words into an external RAM from base_addr, then reads them back and compares sums.
module ram_stream_writer
    import ram_stream_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_len,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]   acc_cnt_q, acc_cnt_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [DATA_W-1:0] rsum_q, rsum_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_vld_q, rd_vld_d;
    logic              acc_vld_q, acc_vld_d;
    logic              pass_q, pass_d;
    logic              err_len_q, err_len_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              hs, gen_clr, wr_step, rd_step;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    wrap_addr_gen #(.ADDR_W(ADDR_W)) u_wr_gen (
        .clk (clk), .rst (rst), .clr (gen_clr), .step (wr_step), .base (base_q), .addr (wr_addr)
    );

    wrap_addr_gen #(.ADDR_W(ADDR_W)) u_rd_gen (
        .clk (clk), .rst (rst), .clr (gen_clr), .step (rd_step), .base (base_q), .addr (rd_addr)
    );

    assign s_ready = (state_q == ST_WRITE);
    assign hs      = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        checksum_d = checksum_q;
        rsum_d     = rsum_q;
        pass_d     = pass_q;
        err_len_d  = 1'b0;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        gen_clr    = 1'b0;
        wr_step    = 1'b0;
        rd_step    = 1'b0;
        rd_vld_d   = 1'b0;
        // Readback pipe: raddr -> rdata (RAM) -> rdata_q -> rsum.
        acc_vld_d  = rd_vld_q;
        rdata_d    = rd_vld_q ? rdata : rdata_q;
        if (acc_vld_q) begin
            rsum_d    = add_mod(rsum_q, rdata_q);
            acc_cnt_d = acc_cnt_q + ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len > DEPTH) begin
                        err_len_d = 1'b1;
                    end else if (len == '0) begin
                        checksum_d = '0;
                        pass_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        base_d     = base_addr;
                        len_d      = len;
                        checksum_d = '0;
                        rsum_d     = '0;
                        pass_d     = 1'b0;
                        wr_cnt_d   = '0;
                        rd_cnt_d   = '0;
                        acc_cnt_d  = '0;
                        gen_clr    = 1'b1;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (hs) begin
                    we_d       = 1'b1;
                    waddr_d    = wr_addr;
                    wdata_d    = s_data;
                    wr_step    = 1'b1;
                    checksum_d = add_mod(checksum_q, s_data);
                    wr_cnt_d   = wr_cnt_q + ONE;
                    if (wr_cnt_q + ONE == len_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            // One idle cycle lets the final registered write land before any read.
            ST_FLUSH: state_d = ST_VERIFY;
            ST_VERIFY: begin
                if (rd_cnt_q != len_q) begin
                    rd_step  = 1'b1;
                    rd_cnt_d = rd_cnt_q + ONE;
                    rd_vld_d = 1'b1;
                end
                if (acc_vld_q && (acc_cnt_q + ONE == len_q)) begin
                    pass_d  = (rsum_d == checksum_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            acc_cnt_q  <= '0;
            checksum_q <= '0;
            rsum_q     <= '0;
            rdata_q    <= '0;
            rd_vld_q   <= 1'b0;
            acc_vld_q  <= 1'b0;
            pass_q     <= 1'b0;
            err_len_q  <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            checksum_q <= checksum_d;
            rsum_q     <= rsum_d;
            rdata_q    <= rdata_d;
            rd_vld_q   <= rd_vld_d;
            acc_vld_q  <= acc_vld_d;
            pass_q     <= pass_d;
            err_len_q  <= err_len_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign raddr    = rd_addr;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign err_len  = err_len_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_ram_stream_writer.sv
// Directed bench for ram_stream_writer with a 256x8 synchronous-read RAM model.
module tb_ram_stream_writer;

    logic       clk = 1'b0;
    logic       rst, start, s_valid, s_ready, we, busy, done, pass, err_len;
    logic [7:0] base_addr, s_data, waddr, wdata, raddr, rdata, checksum;
    logic [8:0] len;

    always #5 clk = ~clk;

    ram_stream_writer dut (
        .clk (clk), .rst (rst), .start (start), .base_addr (base_addr), .len (len),
        .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
        .we (we), .waddr (waddr), .wdata (wdata), .raddr (raddr), .rdata (rdata),
        .busy (busy), .done (done), .pass (pass), .err_len (err_len), .checksum (checksum)
    );

    logic [7:0] mem [0:255];
    logic       corrupt_en;
    logic [7:0] corrupt_addr;

    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr] ^ ((corrupt_en && raddr == corrupt_addr) ? 8'h01 : 8'h00);
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] stream [0:255];
    int         n_we, n_done, done_cyc, busy_rise, busy_fall, err_cyc;
    int         we_cyc [0:255];
    logic [7:0] we_addr [0:255];
    logic [7:0] we_data [0:255];
    logic [7:0] raddr_log [0:2047];
    logic       pass_at_done;
    logic [7:0] cs_at_done;

    // Drives one load from just after a rising edge; cycle 0 is the cycle carrying start.
    task automatic run_load(input logic [7:0] b, input logic [8:0] l, input bit stalls,
                            input int budget);
        int widx;
        bit hs;
        n_we = 0; n_done = 0; done_cyc = -1; busy_rise = -1; busy_fall = -1; err_cyc = -1;
        pass_at_done = 1'b0; cs_at_done = 8'h00;
        widx = 0;
        start = 1'b1; base_addr = b; len = l; s_valid = 1'b0; s_data = 8'h00;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc > 0) begin
                start   = 1'b0;
                s_valid = (widx < int'(l)) && (!stalls || $urandom_range(0, 2) != 0);
                s_data  = s_valid ? stream[widx] : 8'h00;
            end
            @(negedge clk);
            hs = s_valid && s_ready;
            if (we) begin
                if (n_we < 256) begin
                    we_cyc[n_we] = cyc; we_addr[n_we] = waddr; we_data[n_we] = wdata;
                end
                n_we++;
            end
            if (cyc < 2048) raddr_log[cyc] = raddr;
            if (busy && busy_rise < 0) busy_rise = cyc;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; pass_at_done = pass; cs_at_done = checksum;
                end
            end
            if (!busy && done_cyc >= 0 && cyc > done_cyc && busy_fall < 0) busy_fall = cyc;
            if (err_len && err_cyc < 0) err_cyc = cyc;
            if (hs) widx++;
            @(posedge clk); #1;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_ready, we, busy, done, pass, err_len} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {s_ready, we, busy, done, pass, err_len});
        else n_pass++;
        n_checks++;
        if ({waddr, wdata, raddr, checksum} !== 32'h0)
            $display("FAIL reset_data: got %h expected 00000000", {waddr, wdata, raddr, checksum});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
        run_load(8'h00, 9'd4, 1'b0, 40);
        n_checks++;
        if (n_we !== 4) $display("FAIL basic_nwe: got %0d expected 4", n_we); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (we_addr[k] !== 8'(k) || we_data[k] !== stream[k] || we_cyc[k] !== k + 2)
                $display("FAIL basic_write%0d: got addr %h data %h cyc %0d expected %h %h %0d",
                         k, we_addr[k], we_data[k], we_cyc[k], 8'(k), stream[k], k + 2);
            else n_pass++;
        end
        n_checks++;
        if (cs_at_done !== 8'hAA) $display("FAIL basic_checksum: got %h expected aa", cs_at_done); else n_pass++;
        n_checks++;
        if (done_cyc !== 12) $display("FAIL basic_done_cycle: got %0d expected 12", done_cyc); else n_pass++;
        n_checks++;
        if (pass_at_done !== 1'b1) $display("FAIL basic_pass: got %b expected 1", pass_at_done); else n_pass++;
        n_checks++;
        if (busy_rise !== 1 || busy_fall !== 13)
            $display("FAIL basic_busy: got rise %0d fall %0d expected 1 13", busy_rise, busy_fall);
        else n_pass++;
        n_checks++;
        if (n_done !== 1) $display("FAIL basic_done_pulses: got %0d expected 1", n_done); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a;
        for (int k = 0; k < 4; k++) stream[k] = 8'(k + 1);
        run_load(8'hFE, 9'd4, 1'b0, 40);
        for (int k = 0; k < 4; k++) begin
            exp_a = 8'hFE + 8'(k);
            n_checks++;
            if (we_addr[k] !== exp_a) $display("FAIL wrap_waddr%0d: got %h expected %h", k, we_addr[k], exp_a);
            else n_pass++;
            n_checks++;
            if (raddr_log[6 + k] !== exp_a)
                $display("FAIL wrap_raddr%0d: got %h expected %h", k, raddr_log[6 + k], exp_a);
            else n_pass++;
        end
        n_checks++;
        if (pass_at_done !== 1'b1 || cs_at_done !== 8'h0A)
            $display("FAIL wrap_result: got pass %b cs %h expected 1 0a", pass_at_done, cs_at_done);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [7:0] sum;
        int         bad;
        sum = 8'h00; bad = 0;
        for (int k = 0; k < 256; k++) begin
            stream[k] = 8'($urandom_range(0, 255));
            sum = sum + stream[k];
        end
        run_load(8'h37, 9'd256, 1'b1, 2000);
        n_checks++;
        if (n_we !== 256) $display("FAIL full_nwe: got %0d expected 256", n_we); else n_pass++;
        for (int k = 0; k < 256; k++)
            if (we_addr[k] !== 8'h37 + 8'(k) || we_data[k] !== stream[k]) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL full_writes: got %0d bad writes expected 0", bad); else n_pass++;
        n_checks++;
        if (done_cyc < 0 || pass_at_done !== 1'b1)
            $display("FAIL full_pass: got done %0d pass %b expected done pass 1", done_cyc, pass_at_done);
        else n_pass++;
        n_checks++;
        if (cs_at_done !== sum) $display("FAIL full_checksum: got %h expected %h", cs_at_done, sum); else n_pass++;
        n_checks++;
        if (checksum !== sum) $display("FAIL full_checksum_held: got %h expected %h", checksum, sum); else n_pass++;
    endtask

    task automatic test_corrupt();
        for (int k = 0; k < 4; k++) stream[k] = 8'(k + 5);
        corrupt_addr = 8'h11; corrupt_en = 1'b1;
        run_load(8'h10, 9'd4, 1'b0, 40);
        corrupt_en = 1'b0;
        n_checks++;
        if (done_cyc !== 12 || pass_at_done !== 1'b0)
            $display("FAIL corrupt_pass: got done %0d pass %b expected 12 0", done_cyc, pass_at_done);
        else n_pass++;
        n_checks++;
        if (cs_at_done !== 8'h1A) $display("FAIL corrupt_checksum: got %h expected 1a", cs_at_done); else n_pass++;
        n_checks++;
        if (pass !== 1'b0) $display("FAIL corrupt_pass_held: got %b expected 0", pass); else n_pass++;
    endtask

    task automatic test_len0();
        run_load(8'h20, 9'd0, 1'b0, 8);
        n_checks++;
        if (done_cyc !== 1) $display("FAIL len0_done: got %0d expected 1", done_cyc); else n_pass++;
        n_checks++;
        if (pass_at_done !== 1'b1 || cs_at_done !== 8'h00)
            $display("FAIL len0_result: got pass %b cs %h expected 1 00", pass_at_done, cs_at_done);
        else n_pass++;
        n_checks++;
        if (n_we !== 0 || busy_fall !== 2)
            $display("FAIL len0_nowrite: got we %0d busy_fall %0d expected 0 2", n_we, busy_fall);
        else n_pass++;
    endtask

    task automatic test_len_err();
        run_load(8'h00, 9'd300, 1'b0, 8);
        n_checks++;
        if (err_cyc !== 1) $display("FAIL err300_pulse: got %0d expected 1", err_cyc); else n_pass++;
        n_checks++;
        if (busy_rise !== -1 || n_done !== 0 || n_we !== 0)
            $display("FAIL err300_idle: got busy_rise %0d done %0d we %0d expected -1 0 0",
                     busy_rise, n_done, n_we);
        else n_pass++;
        run_load(8'h00, 9'd257, 1'b0, 8);
        n_checks++;
        if (err_cyc !== 1 || busy_rise !== -1)
            $display("FAIL err257: got err %0d busy_rise %0d expected 1 -1", err_cyc, busy_rise);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int extra_we;
        stream[0] = 8'h09; stream[1] = 8'h08; stream[2] = 8'h07; stream[3] = 8'h06;
        start = 1'b1; base_addr = 8'h40; len = 9'd4;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = stream[0];
        @(posedge clk); #1;
        s_data = stream[1];
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = 8'h00; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_ready, we, busy, done, pass, err_len} !== 6'b0 || {waddr, wdata, raddr, checksum} !== 32'h0)
            $display("FAIL midrst_outputs: got %b %h expected 000000 00000000",
                     {s_ready, we, busy, done, pass, err_len}, {waddr, wdata, raddr, checksum});
        else n_pass++;
        extra_we = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (we || busy) extra_we++;
        end
        n_checks++;
        if (extra_we !== 0) $display("FAIL midrst_quiet: got %0d active cycles expected 0", extra_we); else n_pass++;
        @(posedge clk); #1;
        run_load(8'h40, 9'd4, 1'b0, 40);
        n_checks++;
        if (n_we !== 4 || done_cyc !== 12 || pass_at_done !== 1'b1 || cs_at_done !== 8'h1E)
            $display("FAIL midrst_reload: got we %0d done %0d pass %b cs %h expected 4 12 1 1e",
                     n_we, done_cyc, pass_at_done, cs_at_done);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        base_addr = 8'h00; len = 9'd0; corrupt_en = 1'b0; corrupt_addr = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_corrupt();
        test_len0();
        test_len_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
